// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Request/response handshake between a datapath (master) and the data memory
// responder (slave). The 64-bit shared data bus is bidirectional and is kept
// as a plain inout port on the responder rather than being carried here.
//
// Signals:
//   mem_req   master -> slave  request strobe
//   mem_we    master -> slave  1 = write, 0 = read (sampled with mem_req)
//   mem_addr  master -> slave  byte address, ADDR_BITS wide
//   mem_ready slave -> master  one-cycle response pulse
//   mem_busy  slave -> master  request in flight (waiting out the latency)
//   mem_err   slave -> master  misaligned access, valid with mem_ready
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int ADDR_BITS = 6
);
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ready;
    logic                 mem_busy;
    logic                 mem_err;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ready,
        input  mem_busy,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ready,
        output mem_busy,
        output mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Fixed-latency 64-bit word memory that answers single requests from a
// datapath. A request is accepted in IDLE, waits out LATENCY cycles and then
// produces a one-cycle response. Misaligned byte addresses are answered one
// cycle after acceptance with an error flag and have no side effects.
//
// Parameters:
//   ADDR_BITS  byte-address width; storage holds 2^(ADDR_BITS-3) words
//   LATENCY    cycles from the accepting edge to mem_ready (1..15)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       slave side of the request/response handshake
//   mem_data  shared 64-bit data bus: write data is sampled at acceptance,
//             read data is driven only while a good read is responding
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus,
    inout  wire  [63:0]           mem_data
);
    localparam int         IDX_BITS = ADDR_BITS - 3;
    localparam int         DEPTH    = 1 << IDX_BITS;
    localparam logic [3:0] LOAD     = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_count;
    logic [IDX_BITS-1:0] r_word;
    logic                r_we;
    logic                r_err;
    logic [63:0]         r_wdata;
    logic [63:0]         r_rdata;
    logic [63:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_aligned;
    logic                w_lastWait;
    logic                w_enterResp;
    logic                w_useLive;
    logic [IDX_BITS-1:0] w_word;
    logic                w_we;
    logic [63:0]         w_wdata;
    logic                w_drive;

    assign w_accept   = (r_state == IDLE) && bus.mem_req;
    assign w_aligned  = (bus.mem_addr[2:0] == 3'b000);

    // The counter is loaded with LATENCY-1 and the move to RESP happens on
    // the edge where it counts down to zero, so WAIT lasts LATENCY-1 cycles.
    assign w_lastWait = (r_state == WAIT) && (r_count <= 4'd1);

    // Edge at which an aligned access completes: straight from IDLE when the
    // latency is a single cycle, otherwise at the end of WAIT.
    assign w_enterResp = (w_accept && w_aligned && (LATENCY == 1)) || w_lastWait;

    // On the single-cycle path the access completes at the accepting edge,
    // so the live bus has to be used instead of the not-yet-latched copy.
    assign w_useLive = (r_state == IDLE);
    assign w_word    = w_useLive ? bus.mem_addr[ADDR_BITS-1:3] : r_word;
    assign w_we      = w_useLive ? bus.mem_we : r_we;
    assign w_wdata   = w_useLive ? mem_data : r_wdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.mem_req) begin
                    if (!w_aligned || (LATENCY == 1)) begin
                        w_nextState = RESP;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_lastWait) begin
                    w_nextState = RESP;
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture, latency counter, storage and read-data register.
    // Storage sits in this block only so that nothing can be committed while
    // reset is asserted; its contents are never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 64'h0;
            r_rdata <= 64'h0;
        end else begin
            if (w_accept) begin
                r_word  <= bus.mem_addr[ADDR_BITS-1:3];
                r_we    <= bus.mem_we;
                r_wdata <= mem_data;
                r_err   <= !w_aligned;
                r_count <= (w_aligned && (LATENCY > 1)) ? LOAD : 4'd0;
            end else if ((r_state == WAIT) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end

            if (w_enterResp && w_we) begin
                r_mem[w_word] <= w_wdata;
            end

            if (w_enterResp && !w_we) begin
                r_rdata <= r_mem[w_word];
            end
        end
    end

    // Output decode
    always_comb begin
        bus.mem_ready = (r_state == RESP);
        bus.mem_busy  = (r_state == WAIT);
        bus.mem_err   = (r_state == RESP) && r_err;
        w_drive       = (r_state == RESP) && !r_we && !r_err;
    end

    assign mem_data = w_drive ? r_rdata : 64'bz;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Drives two responders side by side, one with LATENCY=2 (A) and one with
// LATENCY=1 (B). Each accepted request pushes its expected response onto a
// per-instance queue; a negedge monitor checks ready/busy/err/data every
// cycle against the head of that queue.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
    localparam int AW    = 6;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    typedef struct {
        logic        isRead;
        logic        err;
        logic [63:0] data;
        int          acc;
        int          due;
    } expResp_t;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [63:0] data;
        logic        expErr;
        logic [63:0] expData;
    } vector_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        reqA    = 1'b0;
    logic        reqB    = 1'b0;
    logic        weIn    = 1'b0;
    logic [5:0]  addrIn  = 6'h0;
    logic [63:0] tbData  = 64'h0;
    logic        tbDrive = 1'b0;
    wire  [63:0] dataA;
    wire  [63:0] dataB;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    expResp_t qA[$];
    expResp_t qB[$];
    vector_t  vec[14];

    data_mem_responder_if #(.ADDR_BITS(AW)) busA ();
    data_mem_responder_if #(.ADDR_BITS(AW)) busB ();

    assign busA.mem_req  = reqA;
    assign busA.mem_we   = weIn;
    assign busA.mem_addr = addrIn;
    assign busB.mem_req  = reqB;
    assign busB.mem_we   = weIn;
    assign busB.mem_addr = addrIn;

    assign dataA = tbDrive ? tbData : 64'bz;
    assign dataB = tbDrive ? tbData : 64'bz;

    data_mem_responder #(.ADDR_BITS(AW), .LATENCY(LAT_A)) dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (busA),
        .mem_data (dataA)
    );

    data_mem_responder #(.ADDR_BITS(AW), .LATENCY(LAT_B)) dutB (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (busB),
        .mem_data (dataB)
    );

    // Clock and cycle counter (cyc holds the number of rising edges seen)
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare one instance's outputs with what the head of its queue implies
    task automatic monitorDut(input int which, input logic ready, input logic busy,
                              input logic err, input logic [63:0] data);
        expResp_t    e;
        logic        haveFront;
        logic        expReady;
        logic        expBusy;
        logic        expErr;
        logic [63:0] seen;
        string       tag;
        tag = (which == 0) ? "A" : "B";
        e = '{isRead: 1'b0, err: 1'b0, data: 64'h0, acc: 0, due: 0};
        if (which == 0) begin
            haveFront = (qA.size() > 0);
            if (haveFront) e = qA[0];
        end else begin
            haveFront = (qB.size() > 0);
            if (haveFront) e = qB[0];
        end
        expReady = haveFront && (cyc == e.due);
        expBusy  = haveFront && !e.err && (cyc >= e.acc) && (cyc < e.due);
        expErr   = expReady && e.err;
        seen     = (data === 64'bz) ? 64'h0 : data;

        checkOutput({tag, ".ready"}, {63'b0, ready}, {63'b0, expReady});
        checkOutput({tag, ".busy"},  {63'b0, busy},  {63'b0, expBusy});
        checkOutput({tag, ".err"},   {63'b0, err},   {63'b0, expErr});
        if (!tbDrive) begin
            if (expReady && e.isRead && !e.err) begin
                checkOutput({tag, ".rdata"}, data, e.data);
            end else begin
                checkOutput({tag, ".dataZ"}, seen, 64'h0);
            end
        end
        if (expReady) begin
            if (which == 0) qA.delete(0);
            else qB.delete(0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            monitorDut(0, busA.mem_ready, busA.mem_busy, busA.mem_err, dataA);
            monitorDut(1, busB.mem_ready, busB.mem_busy, busB.mem_err, dataB);
        end
    end

    // Wait (bounded) until every expected response has been seen
    task automatic waitDrain();
        int n;
        n = 0;
        while (((qA.size() != 0) || (qB.size() != 0)) && (n < 20)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("respTimeout", {63'b0, (n >= 20)}, 64'h0);
        if (n >= 20) begin
            qA.delete();
            qB.delete();
        end
    endtask

    // Issue one request to the selected instances; called just after a
    // rising edge with both instances idle. After acceptance the request
    // inputs are scrambled to show they no longer matter.
    task automatic applyStimulus(input logic we, input logic [5:0] addr, input logic [63:0] data,
                                 input logic expErr, input logic [63:0] expData,
                                 input logic useA, input logic useB);
        expResp_t e;
        e.isRead = !we;
        e.err    = expErr;
        e.data   = expData;
        e.acc    = cyc + 1;
        if (useA) begin
            e.due = expErr ? e.acc : e.acc + LAT_A - 1;
            qA.push_back(e);
        end
        if (useB) begin
            e.due = expErr ? e.acc : e.acc + LAT_B - 1;
            qB.push_back(e);
        end
        reqA    = useA;
        reqB    = useB;
        weIn    = we;
        addrIn  = addr;
        tbData  = data;
        tbDrive = we;
        @(posedge clk);
        #1;
        reqA   = 1'b0;
        reqB   = 1'b0;
        weIn   = !we;
        addrIn = addr ^ 6'h18;
        tbData = ~data;
        waitDrain();
        tbDrive = 1'b0;
    endtask

    initial begin
        expResp_t e;

        vec[0]  = '{1'b1, 6'h08, 64'h0123456789ABCDEF, 1'b0, 64'h0};
        vec[1]  = '{1'b0, 6'h08, 64'h0,                1'b0, 64'h0123456789ABCDEF};
        vec[2]  = '{1'b0, 6'h0B, 64'h0,                1'b1, 64'h0};
        vec[3]  = '{1'b0, 6'h08, 64'h0,                1'b0, 64'h0123456789ABCDEF};
        vec[4]  = '{1'b1, 6'h38, 64'hDEADBEEFCAFEF00D, 1'b0, 64'h0};
        vec[5]  = '{1'b1, 6'h20, 64'h1,                1'b0, 64'h0};
        vec[6]  = '{1'b0, 6'h20, 64'h0,                1'b0, 64'h1};
        vec[7]  = '{1'b0, 6'h38, 64'h0,                1'b0, 64'hDEADBEEFCAFEF00D};
        vec[8]  = '{1'b1, 6'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0};
        vec[9]  = '{1'b0, 6'h00, 64'h0,                1'b0, 64'hFFFFFFFFFFFFFFFF};
        vec[10] = '{1'b1, 6'h18, 64'h5555,             1'b0, 64'h0};
        vec[11] = '{1'b1, 6'h1B, 64'h1234,             1'b1, 64'h0};
        vec[12] = '{1'b0, 6'h18, 64'h0,                1'b0, 64'h5555};
        vec[13] = '{1'b0, 6'h3F, 64'h0,                1'b1, 64'h0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.A.ready", {63'b0, busA.mem_ready}, 64'h0);
        checkOutput("rst.A.busy",  {63'b0, busA.mem_busy},  64'h0);
        checkOutput("rst.A.err",   {63'b0, busA.mem_err},   64'h0);
        checkOutput("rst.B.ready", {63'b0, busB.mem_ready}, 64'h0);
        checkOutput("rst.B.busy",  {63'b0, busB.mem_busy},  64'h0);
        checkOutput("rst.B.err",   {63'b0, busB.mem_err},   64'h0);
        checkOutput("rst.A.dataZ", (dataA === 64'bz) ? 64'h0 : dataA, 64'h0);
        checkOutput("rst.B.dataZ", (dataB === 64'bz) ? 64'h0 : dataB, 64'h0);
        rst_n = 1'b1;

        // Table-driven transactions on both instances
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vec[i].we, vec[i].addr, vec[i].data, vec[i].expErr, vec[i].expData, 1'b1, 1'b1);
        end

        // Back-to-back on A with mem_req held high: write then read of 0x10
        e = '{isRead: 1'b0, err: 1'b0, data: 64'h0, acc: cyc + 1, due: cyc + 2};
        qA.push_back(e);
        e = '{isRead: 1'b1, err: 1'b0, data: 64'hAAAA, acc: cyc + 4, due: cyc + 5};
        qA.push_back(e);
        reqA    = 1'b1;
        weIn    = 1'b1;
        addrIn  = 6'h10;
        tbData  = 64'hAAAA;
        tbDrive = 1'b1;
        @(posedge clk);
        #1;
        weIn    = 1'b0;
        tbDrive = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reqA = 1'b0;
        waitDrain();

        // Reset pulse during WAIT of a write to 0x18 on A
        reqA    = 1'b1;
        weIn    = 1'b1;
        addrIn  = 6'h18;
        tbData  = 64'hFFFF;
        tbDrive = 1'b1;
        @(posedge clk);
        #1;
        reqA    = 1'b0;
        tbDrive = 1'b0;
        checkOutput("abort.busyBefore", {63'b0, busA.mem_busy}, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy",  {63'b0, busA.mem_busy},  64'h0);
        checkOutput("abort.ready", {63'b0, busA.mem_ready}, 64'h0);
        checkOutput("abort.err",   {63'b0, busA.mem_err},   64'h0);
        checkOutput("abort.dataZ", (dataA === 64'bz) ? 64'h0 : dataA, 64'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contents survive reset and the aborted write left no trace
        applyStimulus(1'b0, 6'h18, 64'h0, 1'b0, 64'h5555, 1'b1, 1'b1);
        applyStimulus(1'b0, 6'h10, 64'h0, 1'b0, 64'hAAAA, 1'b1, 1'b0);
        applyStimulus(1'b0, 6'h08, 64'h0, 1'b0, 64'h0123456789ABCDEF, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
